// File: rtl/maf_pipe_slice_pkg.sv
// MAF pipeline stage word: field widths, bit offsets and pack/unpack helpers.
package maf_pipe_pkg;

  localparam int PROD_W = 75;
  localparam int SH_W   = 10;
  localparam int ESH_W  = 2;
  localparam int LVL_W  = 12;
  localparam int SGN_W  = 6;
  localparam int CONT_W = 3;
  localparam int DE_W   = 12;

  // LSB offsets, product at the bottom of the word, E at the top
  localparam int PROD_LSB = 0;
  localparam int SH_LSB   = PROD_LSB + PROD_W;
  localparam int ESH_LSB  = SH_LSB + SH_W;
  localparam int LVLP_LSB = ESH_LSB + ESH_W;
  localparam int LVLN_LSB = LVLP_LSB + LVL_W;
  localparam int SGN_LSB  = LVLN_LSB + LVL_W;
  localparam int CONT_LSB = SGN_LSB + SGN_W;
  localparam int D_LSB    = CONT_LSB + CONT_W;
  localparam int E_LSB    = D_LSB + DE_W;

  localparam int MAF_WORD_W = E_LSB + DE_W;

  typedef logic [MAF_WORD_W-1:0] maf_word_t;

  typedef struct packed {
    logic [DE_W-1:0]   e;
    logic [DE_W-1:0]   d;
    logic [CONT_W-1:0] cont;
    logic [SGN_W-1:0]  sgn;
    logic [LVL_W-1:0]  leveln;
    logic [LVL_W-1:0]  levelp;
    logic [ESH_W-1:0]  esh;
    logic [SH_W-1:0]   sh;
    logic [PROD_W-1:0] prod;
  } maf_stage_t;

  function automatic maf_word_t maf_pack(input maf_stage_t s);
    maf_word_t w;
    w = '0;
    w[PROD_LSB +: PROD_W] = s.prod;
    w[SH_LSB   +: SH_W]   = s.sh;
    w[ESH_LSB  +: ESH_W]  = s.esh;
    w[LVLP_LSB +: LVL_W]  = s.levelp;
    w[LVLN_LSB +: LVL_W]  = s.leveln;
    w[SGN_LSB  +: SGN_W]  = s.sgn;
    w[CONT_LSB +: CONT_W] = s.cont;
    w[D_LSB    +: DE_W]   = s.d;
    w[E_LSB    +: DE_W]   = s.e;
    return w;
  endfunction

  function automatic maf_stage_t maf_unpack(input maf_word_t w);
    maf_stage_t s;
    s.prod   = w[PROD_LSB +: PROD_W];
    s.sh     = w[SH_LSB   +: SH_W];
    s.esh    = w[ESH_LSB  +: ESH_W];
    s.levelp = w[LVLP_LSB +: LVL_W];
    s.leveln = w[LVLN_LSB +: LVL_W];
    s.sgn    = w[SGN_LSB  +: SGN_W];
    s.cont   = w[CONT_LSB +: CONT_W];
    s.d      = w[D_LSB    +: DE_W];
    s.e      = w[E_LSB    +: DE_W];
    return s;
  endfunction

endpackage

// File: rtl/maf_pipe_slice_if.sv
// Valid/ready beat channel carrying one packed MAF stage word.
interface maf_pipe_slice_if #(
  parameter int DATA_W = maf_pipe_pkg::MAF_WORD_W
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/maf_pipe_slice_skid_stage.sv
// One elastic stage: main register plus skid register, ready is registered.
//
// state    | meaning
// ST_EMPTY | no beat held
// ST_FULL  | beat in main, skid free, upstream may push
// ST_SKID  | main and skid both hold beats, upstream blocked
module maf_skid_stage #(
  parameter int DATA_W = maf_pipe_pkg::MAF_WORD_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  // state bits are {main_v, skid_v}
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_FULL  = 2'b10;
  localparam logic [1:0] ST_SKID  = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;
  logic              accept, consume;
  logic              ld_main, ld_skid, main_from_skid;

  assign in_ready_o  = ~state_q[0];
  assign out_valid_o = state_q[1];
  assign out_data_o  = main_q;

  assign accept  = in_valid_i & ~state_q[0];
  assign consume = state_q[1] & out_ready_i;

  assign main_d = main_from_skid ? skid_q : in_data_i;

  // next state and register load enables; flush overrides every transfer
  always_comb begin
    state_d        = state_q;
    ld_main        = 1'b0;
    ld_skid        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_FULL;
          ld_main = 1'b1;
        end
      end
      ST_FULL: begin
        if (accept && consume) begin
          ld_main = 1'b1;
        end else if (accept) begin
          state_d = ST_SKID;
          ld_skid = 1'b1;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (consume) begin
          state_d        = ST_FULL;
          ld_main        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
    end
  end

  // valid flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // data registers move only on their own load event
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main) main_q <= main_d;
      if (ld_skid) skid_q <= in_data_i;
    end
  end

endmodule

// File: rtl/maf_pipe_slice.sv
// Elastic MAF pipeline slice: DEPTH chained skid stages, flush, occupancy.
module maf_pipe_slice
  import maf_pipe_pkg::*;
#(
  parameter int  DATA_W = MAF_WORD_W,
  parameter int  DEPTH  = 1,
  localparam int CNT_W  = $clog2(2*DEPTH+1)
) (
  input  logic             clk,
  input  logic             rstn,
  maf_pipe_slice_if.slave  in_if,
  maf_pipe_slice_if.master out_if,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy
);

  logic              stg_valid [DEPTH+1];
  logic              stg_ready [DEPTH+1];
  logic [DATA_W-1:0] stg_data  [DEPTH+1];
  logic              acc, cons;
  logic [CNT_W-1:0]  occ_q, occ_d;

  // flush hides both ends so no transfer is counted during it
  assign stg_valid[0]     = in_if.valid & ~flush;
  assign stg_data[0]      = in_if.data;
  assign in_if.ready      = stg_ready[0] & ~flush;
  assign stg_ready[DEPTH] = out_if.ready & ~flush;
  assign out_if.valid     = stg_valid[DEPTH] & ~flush;
  assign out_if.data      = stg_data[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    maf_skid_stage #(.DATA_W(DATA_W)) u_stage (
      .clk         (clk),
      .rstn        (rstn),
      .flush_i     (flush),
      .in_valid_i  (stg_valid[k]),
      .in_ready_o  (stg_ready[k]),
      .in_data_i   (stg_data[k]),
      .out_valid_o (stg_valid[k+1]),
      .out_ready_i (stg_ready[k+1]),
      .out_data_o  (stg_data[k+1])
    );
  end

  assign acc  = in_if.valid & in_if.ready;
  assign cons = out_if.valid & out_if.ready;

  // occupancy tracks accepts minus consumes
  always_comb begin
    occ_d = occ_q;
    if (flush)             occ_d = '0;
    else if (acc && !cons) occ_d = occ_q + 1'b1;
    else if (cons && !acc) occ_d = occ_q - 1'b1;
  end

  // occupancy register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_maf_pipe_slice.sv
// Bench for maf_pipe_slice: DEPTH 1, 2 and 3 driven in parallel, checked
// against a per-stage two-entry FIFO model built from queues.
module tb_maf_pipe_slice;
  import maf_pipe_pkg::*;

  localparam int DW = MAF_WORD_W;
  typedef logic [DW-1:0] word_t;

  logic  clk = 1'b0;
  logic  rstn;
  logic  in_valid, out_ready, flush;
  word_t in_data;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maf_pipe_slice_if #(.DATA_W(DW)) in1 (), out1 (), in2 (), out2 (), in3 (), out3 ();

  logic [1:0] occ1;
  logic [2:0] occ2, occ3;

  maf_pipe_slice #(.DATA_W(DW), .DEPTH(1)) u_d1 (
    .clk(clk), .rstn(rstn), .in_if(in1), .out_if(out1), .flush(flush), .occupancy(occ1));
  maf_pipe_slice #(.DATA_W(DW), .DEPTH(2)) u_d2 (
    .clk(clk), .rstn(rstn), .in_if(in2), .out_if(out2), .flush(flush), .occupancy(occ2));
  maf_pipe_slice #(.DATA_W(DW), .DEPTH(3)) u_d3 (
    .clk(clk), .rstn(rstn), .in_if(in3), .out_if(out3), .flush(flush), .occupancy(occ3));

  assign in1.valid = in_valid;  assign in1.data = in_data;  assign out1.ready = out_ready;
  assign in2.valid = in_valid;  assign in2.data = in_data;  assign out2.ready = out_ready;
  assign in3.valid = in_valid;  assign in3.data = in_data;  assign out3.ready = out_ready;

  logic       rdy_w [3];
  logic       vld_w [3];
  word_t      dat_w [3];
  logic [3:0] occ_w [3];

  assign rdy_w[0] = in1.ready;  assign vld_w[0] = out1.valid;  assign dat_w[0] = out1.data;
  assign rdy_w[1] = in2.ready;  assign vld_w[1] = out2.valid;  assign dat_w[1] = out2.data;
  assign rdy_w[2] = in3.ready;  assign vld_w[2] = out3.valid;  assign dat_w[2] = out3.data;
  assign occ_w[0] = {2'b00, occ1};
  assign occ_w[1] = {1'b0, occ2};
  assign occ_w[2] = {1'b0, occ3};

  // model: instance d (DEPTH d+1), stage k is queue mq[d*3+k], at most 2 beats each
  word_t mq [9][$];

  task automatic chk_eq(input string tag, input word_t act, input word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic word_t rand_word();
    return word_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) mq[i].delete();
  endtask

  // called at posedge+1: compare at negedge, advance model, move to next posedge+1
  task automatic step();
    int    s [3];
    int    dep, occ;
    logic  ev;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      dep = d + 1;
      occ = 0;
      for (int k = 0; k < dep; k++) occ += mq[d*3+k].size();
      chk_eq($sformatf("d%0d_in_ready", dep), word_t'(rdy_w[d]),
             word_t'(!flush && mq[d*3].size() < 2));
      ev = !flush && mq[d*3+dep-1].size() > 0;
      chk_eq($sformatf("d%0d_out_valid", dep), word_t'(vld_w[d]), word_t'(ev));
      if (ev) chk_eq($sformatf("d%0d_out_data", dep), dat_w[d], mq[d*3+dep-1][0]);
      chk_eq($sformatf("d%0d_occupancy", dep), word_t'(occ_w[d]), word_t'(occ));
      if (flush) begin
        for (int k = 0; k < dep; k++) mq[d*3+k].delete();
      end else begin
        for (int k = 0; k < dep; k++) s[k] = mq[d*3+k].size();
        if (out_ready && s[dep-1] > 0) void'(mq[d*3+dep-1].pop_front());
        for (int k = dep - 2; k >= 0; k--)
          if (s[k] > 0 && s[k+1] < 2) mq[d*3+k+1].push_back(mq[d*3+k].pop_front());
        if (in_valid && s[0] < 2) mq[d*3].push_back(in_data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk_eq($sformatf("%s_d%0d_out_valid", tag, d + 1), word_t'(vld_w[d]), '0);
      chk_eq($sformatf("%s_d%0d_out_data", tag, d + 1), dat_w[d], '0);
      chk_eq($sformatf("%s_d%0d_occupancy", tag, d + 1), word_t'(occ_w[d]), '0);
    end
  endtask

  maf_stage_t st_in, st_out;
  logic       rt_seen;
  word_t      cnt;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_cleared("rst");
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;

    // single beat through every depth
    in_valid = 1'b1; in_data = word_t'(8'hA5); out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_data = rand_word();
    repeat (5) step();

    // fill with the output stalled, then drain in order
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = word_t'(100 + i);
      step();
    end
    chk_eq("d3_full_occupancy", word_t'(occ_w[2]), word_t'(6));
    chk_eq("d3_full_in_ready", word_t'(rdy_w[2]), '0);
    chk_eq("d1_full_occupancy", word_t'(occ_w[0]), word_t'(2));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) step();

    // random stream of incrementing words with 50% backpressure
    cnt = word_t'(1000);
    for (int i = 0; i < 200; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = in_valid ? cnt : rand_word();
      if (in_valid) cnt = cnt + 1'b1;
      out_ready = $urandom_range(0, 1) == 1;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();

    // flush with three beats held and a beat offered on the flush cycle
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = word_t'(200 + i);
      step();
    end
    chk_eq("pre_flush_d3_occupancy", word_t'(occ_w[2]), word_t'(3));
    flush = 1'b1; in_data = word_t'(299);
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    repeat (4) step();

    // reset while every stage sits in SKID
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = word_t'(300 + i);
      step();
    end
    #2;
    rstn = 1'b0; in_valid = 1'b0;
    model_clear();
    #1;
    check_cleared("midrst");
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = word_t'(16'hBEEF); out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_data = rand_word();
    repeat (4) step();

    // field round trip through the deepest slice
    st_in        = maf_unpack(rand_word());
    st_in.prod   = 75'h1;
    st_in.sh     = 10'h3FF;
    st_in.e      = 12'h800;
    st_in.sgn    = '1;
    in_valid = 1'b1; in_data = maf_pack(st_in); out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_data = rand_word();
    rt_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (vld_w[2] && !rt_seen) begin
        rt_seen = 1'b1;
        st_out  = maf_unpack(dat_w[2]);
        chk_eq("rt_prod",   word_t'(st_out.prod),   word_t'(75'h1));
        chk_eq("rt_sh",     word_t'(st_out.sh),     word_t'(10'h3FF));
        chk_eq("rt_e",      word_t'(st_out.e),      word_t'(12'h800));
        chk_eq("rt_sgn",    word_t'(st_out.sgn),    word_t'(6'h3F));
        chk_eq("rt_esh",    word_t'(st_out.esh),    word_t'(st_in.esh));
        chk_eq("rt_levelp", word_t'(st_out.levelp), word_t'(st_in.levelp));
        chk_eq("rt_leveln", word_t'(st_out.leveln), word_t'(st_in.leveln));
        chk_eq("rt_cont",   word_t'(st_out.cont),   word_t'(st_in.cont));
        chk_eq("rt_d",      word_t'(st_out.d),      word_t'(st_in.d));
      end
      step();
    end
    if (!rt_seen) chk_eq("rt_seen", '0, word_t'(1));

    // random traffic with occasional flush
    for (int i = 0; i < 200; i++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = rand_word();
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 19) == 0;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
